// File: rtl/parking_gate_controller_if.sv
// Gate-controller bus: request/sensor inputs toward the controller, gate and occupancy status back.
// The master side drives requests and the sensor pulse; the slave side is the controller.
interface parking_gate_controller_if #(
    parameter int unsigned CNT_W = 3
);
    logic             entry_req;
    logic             exit_req;
    logic             car_passed;
    logic             entry_gate;
    logic             exit_gate;
    logic [CNT_W-1:0] parked;
    logic [CNT_W-1:0] empty;
    logic             full;
    logic             entry_denied;
    logic             busy;

    modport master (
        output entry_req,
        output exit_req,
        output car_passed,
        input  entry_gate,
        input  exit_gate,
        input  parked,
        input  empty,
        input  full,
        input  entry_denied,
        input  busy
    );

    modport slave (
        input  entry_req,
        input  exit_req,
        input  car_passed,
        output entry_gate,
        output exit_gate,
        output parked,
        output empty,
        output full,
        output entry_denied,
        output busy
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Entry/exit gate sequencer and lot occupancy counter with round-robin arbitration.
// Optional open-gate timeout is enabled by defining GATE_TIMEOUT_EN.
module parking_gate_controller #(
    parameter int unsigned CAPACITY = 7,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned TIMEOUT  = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    parking_gate_controller_if.slave gate_bus
);

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StOpenEntry = 2'd1;
    localparam logic [1:0] StOpenExit  = 2'd2;
    localparam logic [1:0] StClose     = 2'd3;

    localparam logic [CNT_W-1:0] CapVal = CNT_W'(CAPACITY);

    if (CAPACITY < 1 || CAPACITY > (2 ** CNT_W) - 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("parking_gate_controller: illegal CAPACITY/CNT_W/TIMEOUT combination");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] parked_q, parked_d;
    logic             entry_gate_q, entry_gate_d;
    logic             exit_gate_q, exit_gate_d;
    logic             denied_q, denied_d;
    // High when the exit side should win the next simultaneous request.
    logic             rr_exit_q, rr_exit_d;

    logic full;
    logic entry_ok;
    logic exit_ok;
    logic tmo_hit;

    assign full     = (parked_q == CapVal);
    assign entry_ok = gate_bus.entry_req && !full;
    assign exit_ok  = gate_bus.exit_req && (parked_q != '0);

`ifdef GATE_TIMEOUT_EN
    localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Held at zero outside the open states, so every grant starts a fresh count.
    always_comb begin
        tmo_d = '0;
        if (state_q == StOpenEntry || state_q == StOpenExit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q == TmoLast);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        parked_d  = parked_q;
        rr_exit_d = rr_exit_q;
        denied_d  = 1'b0;

        case (state_q)
            StIdle: begin
                denied_d = gate_bus.entry_req && full;
                if (entry_ok && (!exit_ok || !rr_exit_q)) begin
                    state_d   = StOpenEntry;
                    rr_exit_d = 1'b1;
                end else if (exit_ok) begin
                    state_d   = StOpenExit;
                    rr_exit_d = 1'b0;
                end
            end
            StOpenEntry: begin
                if (gate_bus.car_passed) begin
                    state_d = StClose;
                    if (parked_q != CapVal) begin
                        parked_d = parked_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = StClose;
                end
            end
            StOpenExit: begin
                if (gate_bus.car_passed) begin
                    state_d = StClose;
                    if (parked_q != '0) begin
                        parked_d = parked_q - 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = StClose;
                end
            end
            StClose: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        entry_gate_d = (state_d == StOpenEntry);
        exit_gate_d  = (state_d == StOpenExit);
    end

    // Gates sit on async-reset flops so a reset drops the barriers without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            parked_q     <= '0;
            entry_gate_q <= 1'b0;
            exit_gate_q  <= 1'b0;
            denied_q     <= 1'b0;
            rr_exit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            parked_q     <= parked_d;
            entry_gate_q <= entry_gate_d;
            exit_gate_q  <= exit_gate_d;
            denied_q     <= denied_d;
            rr_exit_q    <= rr_exit_d;
        end
    end

    assign gate_bus.entry_gate   = entry_gate_q;
    assign gate_bus.exit_gate    = exit_gate_q;
    assign gate_bus.parked       = parked_q;
    assign gate_bus.empty        = CapVal - parked_q;
    assign gate_bus.full         = full;
    assign gate_bus.entry_denied = denied_q;
    assign gate_bus.busy         = (state_q != StIdle);

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequences the lot's entry and exit gates and owns the occupancy count that the free-slot datapath consumes. It arbitrates between entry and exit requests and opens one gate at a time. It updates `parked` only when the pass-through sensor confirms a car, and presents `empty = CAPACITY - parked` to the display and status logic.

## Interface
- `CAPACITY`, default 7: number of slots; must satisfy 1 ≤ CAPACITY ≤ 2^CNT_W − 1.
- `CNT_W`, default 3: width of the occupancy and free-slot counts.
- `TIMEOUT`, default 16: cycles a gate may stay open without `car_passed`. Used only when `GATE_TIMEOUT_EN` is defined.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `entry_req` in 1: level; a car is waiting at the entry.
- `exit_req` in 1: level; a car is waiting at the exit.
- `car_passed` in 1: one-cycle pulse from the gate sensor; the car has cleared the open gate.
- `entry_gate` out 1: registered; high means the entry barrier is open.
- `exit_gate` out 1: registered; high means the exit barrier is open.
- `parked` out CNT_W: registered occupancy count.
- `empty` out CNT_W: combinational `CAPACITY - parked`.
- `full` out 1: combinational, `parked == CAPACITY`.
- `entry_denied` out 1: registered one-cycle pulse; an entry request was refused because the lot is full.
- `busy` out 1: combinational; state is not IDLE.

## Operation
- FSM states: IDLE, OPEN_ENTRY, OPEN_EXIT, CLOSE.
- IDLE:
  - A request is eligible as follows: entry is eligible when `entry_req && !full`; exit is eligible when `exit_req && parked != 0`.
  - If exactly one request is eligible, grant it: go to OPEN_ENTRY or OPEN_EXIT.
  - If both are eligible, a round-robin pointer picks the side not granted last. After reset the pointer favours entry.
  - The pointer updates on every grant.
  - If `entry_req && full`, pulse `entry_denied` for one cycle and remain in IDLE. This pulse repeats every IDLE cycle while the request is held. An exit grant in the same cycle still proceeds.
  - `exit_req` with `parked == 0` is ignored silently.
- OPEN_ENTRY / OPEN_EXIT:
  - The corresponding gate output is high; the other gate is low.
  - On `car_passed`: OPEN_ENTRY increments `parked`, OPEN_EXIT decrements it, then go to CLOSE.
  - `parked` never exceeds CAPACITY and never goes below 0. The eligibility checks guarantee this, and the RTL must additionally saturate.
  - Requests are ignored while a gate is open.
- CLOSE: both gates are low for exactly one cycle, then return to IDLE. This is the barrier-down guard.
- `car_passed` outside the OPEN states is ignored.
- Requests are level-sensitive. A request still held on return to IDLE is treated as a new car and is re-granted.

## Timing
- Reset values:
  - state = IDLE
  - `entry_gate` = `exit_gate` = 0
  - `parked` = 0, so `empty` = CAPACITY and `full` = 0
  - `entry_denied` = 0, `busy` = 0
  - round-robin pointer = entry-first
- Grant latency: a request sampled at edge N sets the gate high after edge N, visible in cycle N+1.
- `car_passed` sampled high at edge M:
  - `parked` updates and the gate drops after edge M.
  - The state is CLOSE for cycle M+1 and IDLE from M+2.
- Minimum request-to-request turnaround: 3 cycles. This is 1 cycle OPEN, when `car_passed` arrives in the first open cycle, plus 1 CLOSE cycle plus 1 IDLE cycle.
- `rst_n` low at any time, including mid-OPEN:
  - Gates close immediately, without waiting for a clock edge.
  - `parked` is cleared.
  - The FSM returns to IDLE.

## Configuration
- `GATE_TIMEOUT_EN` defined:
  - A counter of width ⌈log2(TIMEOUT+1)⌉ clears on entry to an OPEN state and increments each open cycle.
  - If it reaches TIMEOUT without `car_passed`, go to CLOSE with `parked` unchanged.
  - If `car_passed` arrives in the same cycle as the timeout, `car_passed` wins and the count updates.
- `GATE_TIMEOUT_EN` undefined:
  - No counter is synthesised.
  - An OPEN state is held until `car_passed` or reset.

## Test plan
- Reset then idle: `parked`=0, `empty`=7, both gates 0, `busy`=0.
- `entry_req` pulse, then `car_passed` 2 cycles after the gate opens: `entry_gate` high for 3 cycles, then `parked`=1, `empty`=6, one CLOSE cycle.
- `entry_req` and `exit_req` both held with `parked`=3:
  - Grants alternate entry, exit, entry, …
  - `parked` after each pass: 4, 3, 4.
- `parked`=7 with `entry_req` held: `entry_denied` pulses every IDLE cycle, no gate opens, `full`=1. A concurrent `exit_req` is granted and `parked` drops to 6.
- `exit_req` with `parked`=0: no gate activity, `busy` stays 0.
- With `GATE_TIMEOUT_EN`, TIMEOUT=16, and no `car_passed`: the gate closes after 16 open cycles and `parked` is unchanged. Without the macro, the gate is still open after 100 cycles.
- `rst_n` asserted mid-OPEN_EXIT with `parked`=5: gate low asynchronously, `parked`=0, IDLE after release.
